// File: rtl/mem_pkg.sv
// Shared types for the RAM access arbiter: load/store op codes, FSM states
// and the op-to-state routing used at grant time.
package mem_pkg;

   typedef enum logic [2:0] {
      LOAD   = 3'b001,
      STORE  = 3'b010,
      LOADV  = 3'b011,
      STOREV = 3'b100,
      PEEK   = 3'b101
   } load_store_op_set;

   typedef enum logic [1:0] {IDLE, P_ACCESS, V_ACCESS, DONE} state_t;

   // Unknown codes skip the RAMs and report an error straight from DONE.
   function automatic state_t op_route(input logic [2:0] op);
      case (op)
         LOAD, STORE, PEEK: op_route = P_ACCESS;
         LOADV, STOREV:     op_route = V_ACCESS;
         default:           op_route = DONE;
      endcase
   endfunction

   function automatic logic op_is_write(input logic [2:0] op);
      return (op == STORE) || (op == STOREV);
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. Index 0 = load/store, index 1 = fetch.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   // 1 = index 1 won last, so index 0 is preferred next (reset state).
   logic last_hi;

   always_ff @(posedge clk) begin
      if (reset)
         last_hi <= 1'b1;
      else if (update && (grant != 2'b00))
         last_hi <= grant[1];
   end

   always_comb begin
      grant = req;
      if (req == 2'b11)
         grant = last_hi ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Serialises instruction fetch and load/store traffic onto the program (p)
// and vector (v) RAMs, one transaction at a time.
module ram_access_arbiter
   import mem_pkg::*;
#(
   parameter int INPUT_ADDRESS_WIDTH = 16,
   parameter int INPUT_DATA_WIDTH    = 16,
   parameter int RAM_LATENCY         = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           fetch_req,
   input  logic [INPUT_ADDRESS_WIDTH-1:0] program_counter_address,
   output logic                           fetch_ack,
   output logic [INPUT_DATA_WIDTH-1:0]    fetch_data,
   input  logic                           ls_req,
   input  logic [2:0]                     ls_op,
   input  logic [INPUT_ADDRESS_WIDTH-1:0] ls_address,
   input  logic [INPUT_DATA_WIDTH-1:0]    ls_wdata,
   output logic                           ls_ack,
   output logic [INPUT_DATA_WIDTH-1:0]    ls_rdata,
   output logic                           ls_err,
   output logic                           p_ram_rw,
   output logic [INPUT_ADDRESS_WIDTH-1:0] p_ram_address,
   output logic [INPUT_DATA_WIDTH-1:0]    p_ram_data,
   input  logic [INPUT_DATA_WIDTH-1:0]    p_ram_rdata,
   output logic                           v_ram_rw,
   output logic [INPUT_ADDRESS_WIDTH-1:0] v_ram_address,
   output logic [INPUT_DATA_WIDTH-1:0]    v_ram_data,
   input  logic [INPUT_DATA_WIDTH-1:0]    v_ram_rdata,
   output logic                           busy
);

   localparam int AW = INPUT_ADDRESS_WIDTH;
   localparam int DW = INPUT_DATA_WIDTH;

   state_t          state, state_nxt;
   logic [1:0]      gnt;
   logic            take;
   logic            fetch_q, wr_q, err_q;
   logic [AW-1:0]   addr_q, v_addr_q;
   logic [DW-1:0]   wdata_q;
   logic [2:0]      cnt;
   logic            last_cyc;
   logic            in_access;

   assign take      = (state == IDLE) && (gnt != 2'b00);
   assign in_access = (state == P_ACCESS) || (state == V_ACCESS);
   assign last_cyc  = (cnt == 3'(RAM_LATENCY - 1));

   rr_arbiter_2 u_rr (
      .clk    (clk),
      .reset  (reset),
      .req    ({fetch_req, ls_req}),
      .update (take),
      .grant  (gnt)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (gnt[1])      state_nxt = P_ACCESS;
            else if (gnt[0]) state_nxt = op_route(ls_op);
         end
         P_ACCESS, V_ACCESS: if (wr_q || last_cyc) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_q    <= 1'b0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         v_addr_q   <= '0;
         wdata_q    <= '0;
         cnt        <= '0;
         fetch_data <= '0;
         ls_rdata   <= '0;
      end else begin
         if (take) begin
            fetch_q <= gnt[1];
            wr_q    <= gnt[0] && op_is_write(ls_op);
            err_q   <= gnt[0] && (op_route(ls_op) == DONE);
            wdata_q <= ls_wdata;
            cnt     <= '0;
            if (gnt[1])              addr_q <= program_counter_address;
            else if (ls_op == PEEK)  addr_q <= program_counter_address + 1'b1;
            else                     addr_q <= ls_address;
            // The v address is a register so it keeps its value between accesses.
            if (gnt[0] && (op_route(ls_op) == V_ACCESS)) v_addr_q <= ls_address;
            if (gnt[0] && (op_route(ls_op) == DONE))     ls_rdata <= '0;
         end
         if (in_access) begin
            cnt <= cnt + 3'd1;
            if (!wr_q && last_cyc) begin
               if (fetch_q)
                  fetch_data <= (state == P_ACCESS) ? p_ram_rdata : v_ram_rdata;
               else
                  ls_rdata   <= (state == P_ACCESS) ? p_ram_rdata : v_ram_rdata;
            end
         end
      end
   end

   always_comb begin
      busy          = (state != IDLE);
      fetch_ack     = (state == DONE) && fetch_q;
      ls_ack        = (state == DONE) && !fetch_q;
      ls_err        = (state == DONE) && err_q;
      p_ram_rw      = (state == P_ACCESS) && wr_q;
      v_ram_rw      = (state == V_ACCESS) && wr_q;
      p_ram_data    = p_ram_rw ? wdata_q : '0;
      v_ram_data    = v_ram_rw ? wdata_q : '0;
      p_ram_address = (state == P_ACCESS) ? addr_q : program_counter_address;
      v_ram_address = (state == V_ACCESS) ? addr_q : v_addr_q;
   end

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameters SHALL be: INPUT_ADDRESS_WIDTH, default 16, address width; INPUT_DATA_WIDTH, default 16, data width; RAM_LATENCY, default 2, cycles from address to valid read data (range 1..7).
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  instruction-fetch request, held until fetch_ack
- program_counter_address  in  ADDR  fetch address; PEEK base
- fetch_ack  out  1  one-cycle pulse, fetch complete
- fetch_data  out  DATA  fetched word, valid with fetch_ack
- ls_req  in  1  load/store request, held until ls_ack
- ls_op  in  3  load_store_op_set code
- ls_address  in  ADDR  register pair {E,F} address
- ls_wdata  in  DATA  register pair {G,H} store data
- ls_ack  out  1  one-cycle pulse, load/store complete
- ls_rdata  out  DATA  load/peek result, valid with ls_ack
- ls_err  out  1  pulses with ls_ack for an illegal ls_op
- p_ram_rw, v_ram_rw  out  1  1 = write, 0 = read
- p_ram_address, v_ram_address  out  ADDR  RAM addresses
- p_ram_data, v_ram_data  out  DATA  RAM write data
- p_ram_rdata, v_ram_rdata  in  DATA  RAM read data
- busy  out  1  high whenever state is not IDLE

Function
REQ-003 The FSM SHALL have states IDLE, P_ACCESS, V_ACCESS, DONE, and SHALL serve exactly one transaction at a time.
REQ-004 In IDLE, when only one of fetch_req or ls_req is high, that request SHALL be granted on the next edge.
REQ-005 When fetch_req and ls_req are both high in IDLE, grant SHALL alternate between them by round-robin on a last-granted flag. After reset, ls is preferred first.
REQ-006 At grant, the address, the op and the write data SHALL be latched. Input changes during the transaction SHALL be ignored.
REQ-007 Routing by granted op:
- fetch, LOAD (001), STORE (010), PEEK (101) -> P_ACCESS
- LOADV (011), STOREV (100) -> V_ACCESS
- illegal codes (000, 110, 111) -> DONE directly, with ls_err=1, ls_rdata=0 and no RAM access.
REQ-008 The PEEK address SHALL be program_counter_address+1, truncated to ADDR bits, so 0xFFFF wraps to 0x0000.
REQ-009 Reads SHALL drive rw=0 and hold the address for exactly RAM_LATENCY cycles. On the last of those cycles, p_ram_rdata or v_ram_rdata SHALL be captured into fetch_data or ls_rdata.
REQ-010 Writes SHALL drive rw=1 together with the address and data for exactly one cycle, then go to DONE.
REQ-011 DONE SHALL last one cycle. It pulses fetch_ack or ls_ack, then returns to IDLE. A request SHALL NOT be granted in DONE, so the minimum spacing between grants is one idle cycle.
REQ-012 Latency from grant edge to ack:
- read: RAM_LATENCY+1 cycles
- write: 2 cycles
- illegal op: 1 cycle
REQ-013 Outside an access state, rw SHALL be 0 and the data outputs SHALL be 0. p_ram_address SHALL follow program_counter_address, and v_ram_address SHALL hold its last value.
REQ-014 fetch_data and ls_rdata SHALL hold their values until the next capture.

Reset
REQ-015 Reset SHALL take effect on the clk edge and return the block to:
- state IDLE, busy=0
- all acks, ls_err, rw outputs, data outputs, fetch_data, ls_rdata, v_ram_address and the latency counter at 0
- last-granted flag set to prefer ls
REQ-016 Reset mid-transaction SHALL abort the transaction with no ack. A write in progress SHALL see rw fall to 0 on the reset edge.

Structure
REQ-017 Shared package mem_pkg SHALL hold the load_store_op_set enum (LOAD=001, STORE=010, LOADV=011, STOREV=100, PEEK=101) and the FSM state typedef.
REQ-018 Round-robin grant logic SHALL be a sub-module rr_arbiter_2: two requests in, one-hot grant out, with an update strobe.

Verification
REQ-019 Fetch alone, program_counter_address=0x0040, p_ram_rdata=0xBEEF, RAM_LATENCY=2 -> p_ram_address=0x0040 for 2 cycles; fetch_ack and fetch_data=0xBEEF 3 cycles after grant.
REQ-020 STOREV with ls_address=0x1234 and ls_wdata=0xA5A5 -> v_ram_rw=1 for exactly one cycle with those values; ls_ack follows on the next cycle.
REQ-021 fetch_req and ls_req (LOAD) held high continuously -> grants alternate ls, fetch, ls, fetch, with one DONE cycle between consecutive grants.
REQ-022 PEEK with program_counter_address=0xFFFF -> p_ram_address=0x0000; ls_rdata equals p_ram_rdata.
REQ-023 ls_op=111 -> ls_ack and ls_err pulse together 1 cycle after grant; ls_rdata=0; both rw outputs stay 0.
REQ-024 Reset asserted in the 2nd read cycle -> busy=0, no ack, and a new request is granted normally after reset.
